grad_frame_ctrl: RTL and testbench

Frame sequencer for the Sobel gradient engine. It accepts a raster pixel stream through a valid/ready handshake and gates the engine enable. It injects a zero-pixel flush after the last line so the final output row is computed. It tags the engine's gradient output with frame and line markers and forces border pixels to zero.

---
 rtl/grad_pkg.sv | 20 ++
 rtl/grad_frame_ctrl_if.sv | 25 ++
 rtl/grad_tag_pipe.sv | 28 ++
 rtl/grad_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_grad_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grad_pkg.sv
// Shared types for the Sobel frame sequencer: FSM states, gradient data width
// and the per-output tag carried alongside the engine latency.
package grad_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } grad_state_e;

    localparam int GRAD_DW = 14;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
        logic eof;
        logic border;
    } grad_tag_t;
endpackage

// File: rtl/grad_frame_ctrl_if.sv
// Pixel input stream and tagged gradient output stream of the frame sequencer.
// Handshake: a pixel transfers on every rising edge where pix_valid and pix_ready
// are both high; the output stream has no backpressure and is valid when out_valid=1.
interface grad_frame_ctrl_if;
    import grad_pkg::*;

    logic               pix_valid;
    logic [7:0]         pix_data;
    logic               pix_ready;
    logic               out_valid;
    logic [GRAD_DW-1:0] out_data;
    logic               out_sof;
    logic               out_eol;
    logic               out_eof;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, out_valid, out_data, out_sof, out_eol, out_eof
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, out_valid, out_data, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/grad_tag_pipe.sv
// Clearable LAT-deep shift register of output tags; advances every cycle so the
// tag leaves the last stage exactly when the engine result for its centre is registered.
module grad_tag_pipe
    import grad_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_clr,
    input  grad_tag_t i_tag,
    output grad_tag_t o_tag
);
    grad_tag_t r_stage [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[LAT-1];
endmodule

// File: rtl/grad_frame_ctrl.sv
// Frame sequencer for the Sobel gradient engine: gates the engine, injects the
// trailing flush, tags outputs. Optional GRAD_CTRL_STATS_EN adds frame/stall counters.
module grad_frame_ctrl
    import grad_pkg::*;
#(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 768,
    parameter int LAT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    grad_frame_ctrl_if.slave   bus,
    output logic               eng_en,
    output logic [7:0]         eng_gray,
    input  logic [GRAD_DW-1:0] eng_data,
    output logic               busy,
    output logic               done,
`ifdef GRAD_CTRL_STATS_EN
    output logic [15:0]        frame_cnt,
    output logic [31:0]        stall_cnt,
`endif
    output grad_state_e        dbg_state
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int IW   = $clog2(NPIX + IMG_W + 2);
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);

    localparam logic [IW-1:0] IDX_LAST_PIX   = IW'(NPIX - 1);
    localparam logic [IW-1:0] IDX_LAST_FLUSH = IW'(NPIX + IMG_W);
    localparam logic [IW-1:0] IDX_PRIME      = IW'(IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST       = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST       = RW'(IMG_H - 1);

    grad_state_e        r_state;
    logic               r_pix_ready;
    logic               r_busy;
    logic               r_done;
    logic [IW-1:0]      r_in_idx;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [GRAD_DW-1:0] r_eng_q;
    logic               w_push;
    grad_tag_t          w_tag;
    grad_tag_t          w_out;

    assign eng_en   = (r_state == ST_FLUSH) | (bus.pix_valid & r_pix_ready);
    assign eng_gray = r_pix_ready ? bus.pix_data : 8'd0;
    // The first IMG_W+1 enables only prime the engine window; they have no centre yet.
    assign w_push   = eng_en && (r_in_idx >= IDX_PRIME);

    always_comb begin
        w_tag = '0;
        if (w_push) begin
            w_tag.valid  = 1'b1;
            w_tag.sof    = (r_row == '0) && (r_col == '0);
            w_tag.eol    = (r_col == COL_LAST);
            w_tag.eof    = (r_row == ROW_LAST) && (r_col == COL_LAST);
            w_tag.border = (r_row == '0) || (r_row == ROW_LAST) ||
                           (r_col == '0) || (r_col == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_idx    <= '0;
            r_col       <= '0;
            r_row       <= '0;
        end else if (abort) begin
            r_state     <= ST_IDLE;
            r_pix_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_idx    <= '0;
            r_col       <= '0;
            r_row       <= '0;
        end else begin
            r_done <= 1'b0;
            if (eng_en) r_in_idx <= r_in_idx + IW'(1);
            if (w_push) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state     <= ST_RUN;
                    r_pix_ready <= 1'b1;
                    r_busy      <= 1'b1;
                    r_in_idx    <= '0;
                    r_col       <= '0;
                    r_row       <= '0;
                end
                ST_RUN: if (eng_en && (r_in_idx == IDX_LAST_PIX)) begin
                    r_state     <= ST_FLUSH;
                    r_pix_ready <= 1'b0;
                end
                ST_FLUSH: if (r_in_idx == IDX_LAST_FLUSH) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_out.valid && w_out.eof) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Engine result is captured on the same edge its tag enters the last pipe stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_eng_q <= '0;
        else        r_eng_q <= eng_data;
    end

    grad_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (abort),
        .i_tag (w_tag),
        .o_tag (w_out)
    );

    assign bus.pix_ready = r_pix_ready;
    assign bus.out_valid = w_out.valid;
    assign bus.out_data  = (w_out.valid && !w_out.border) ? r_eng_q : '0;
    assign bus.out_sof   = w_out.sof;
    assign bus.out_eol   = w_out.eol;
    assign bus.out_eof   = w_out.eof;
    assign busy          = r_busy;
    assign done          = r_done;
    assign dbg_state     = r_state;

`ifdef GRAD_CTRL_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_done) r_frame_cnt <= r_frame_cnt + 16'd1;
            if ((r_state == ST_IDLE) && start && !abort) r_stall_cnt <= '0;
            else if ((r_state == ST_RUN) && !bus.pix_valid) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_grad_frame_ctrl.sv
// Self-checking bench for grad_frame_ctrl on an 8x4 image with a behavioural engine
// whose result is a fixed function of the window centre pixel.
module tb_grad_frame_ctrl;
    import grad_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int LAT   = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic               eng_en;
    logic [7:0]         eng_gray;
    logic [GRAD_DW-1:0] eng_data;
    logic               busy;
    logic               done;
    grad_state_e        dbg_state;
`ifdef GRAD_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic [31:0] stall_cnt;
`endif

    grad_frame_ctrl_if u_if ();

    grad_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bus       (u_if),
        .eng_en    (eng_en),
        .eng_gray  (eng_gray),
        .eng_data  (eng_data),
        .busy      (busy),
        .done      (done),
`ifdef GRAD_CTRL_STATS_EN
        .frame_cnt (frame_cnt),
        .stall_cnt (stall_cnt),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural engine ----------------
    logic [7:0]         eng_hist [IMG_W+1];
    logic [GRAD_DW-1:0] eng_pipe [LAT-1];

    initial begin
        for (int i = 0; i <= IMG_W; i++) eng_hist[i] = 8'd0;
        for (int i = 0; i < LAT-1; i++) eng_pipe[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = LAT-2; i > 0; i--) eng_pipe[i] <= eng_pipe[i-1];
        eng_pipe[0] <= eng_en ? {4'ha, eng_hist[IMG_W], eng_hist[IMG_W][7:6]}
                              : GRAD_DW'($urandom);
        if (eng_en) begin
            for (int i = IMG_W; i > 0; i--) eng_hist[i] <= eng_hist[i-1];
            eng_hist[0] <= eng_gray;
        end
    end

    assign eng_data = eng_pipe[LAT-2];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_word();
        return 32'({u_if.pix_ready, eng_en, eng_gray, u_if.out_valid, u_if.out_data,
                    u_if.out_sof, u_if.out_eol, u_if.out_eof, busy, done});
    endfunction

    function automatic logic [16:0] exp_word(input int k, input logic [7:0] p);
        int row = k / IMG_W;
        int col = k % IMG_W;
        logic border = (row == 0) || (row == IMG_H-1) || (col == 0) || (col == IMG_W-1);
        logic [GRAD_DW-1:0] d = border ? '0 : {4'ha, p, p[7:6]};
        return {(k == 0), (col == IMG_W-1), (k == NPIX-1), d};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [16:0] exp_q[$];
    logic [7:0]  pix_tbl [NPIX];
    int out_cnt = 0;
    int flush_cnt = 0;
    int done_cnt = 0;
    int stall_cycles = 0;
    int frames_done = 0;
    logic prev_eof = 1'b0;

    always @(negedge clk) begin
        logic [16:0] e;
        if (u_if.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(u_if.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_word", 32'({u_if.out_sof, u_if.out_eol, u_if.out_eof, u_if.out_data}),
                      32'(e));
                out_cnt++;
            end
        end
        if (eng_en && !u_if.pix_ready) begin
            flush_cnt++;
            check("flush_gray", 32'(eng_gray), 32'd0);
        end
        if (done || prev_eof) check("done_after_eof", 32'(done), 32'(prev_eof));
        if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
        prev_eof = u_if.out_valid & u_if.out_eof;
    end

    // ---------------- driver tasks ----------------
    task automatic begin_frame(input bit regen);
        if (regen) for (int k = 0; k < NPIX; k++) pix_tbl[k] = 8'($urandom_range(0, 255));
        out_cnt = 0;
        flush_cnt = 0;
        done_cnt = 0;
        stall_cycles = 0;
        check("ready_idle", 32'(u_if.pix_ready), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ready_after_start", 32'(u_if.pix_ready), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_pixels(input int stall_pct, input int n, input int start_at);
        int t;
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(0, 99) < stall_pct) begin
                u_if.pix_valid = 1'b0;
                @(posedge clk); #1;
                stall_cycles++;
            end
            if (k == start_at) start = 1'b1;
            u_if.pix_valid = 1'b1;
            u_if.pix_data  = pix_tbl[k];
            t = 0;
            while (!u_if.pix_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!u_if.pix_ready) check("ready_timeout", 32'(u_if.pix_ready), 32'd1);
            @(posedge clk); #1;
            start = 1'b0;
            exp_q.push_back(exp_word(k, pix_tbl[k]));
        end
        u_if.pix_valid = 1'b0;
    endtask

    task automatic finish_frame();
        int t = 0;
        while (done_cnt == 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("done_seen", 32'(done_cnt), 32'd1);
        check("frame_outputs", 32'(out_cnt), 32'(NPIX));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("flush_enables", 32'(flush_cnt), 32'(IMG_W + 1));
        check("idle_after_done", 32'(dbg_state), 32'(ST_IDLE));
        frames_done++;
`ifdef GRAD_CTRL_STATS_EN
        check("frame_cnt", 32'(frame_cnt), 32'(frames_done));
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        u_if.pix_valid = 1'b0;
        u_if.pix_data  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs_word(), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // continuous stream
        begin_frame(1'b1);
        send_pixels(0, NPIX, -1);
        finish_frame();

        // 50% stalls, same pixel values
        begin_frame(1'b0);
        send_pixels(50, NPIX, -1);
        finish_frame();
`ifdef GRAD_CTRL_STATS_EN
        check("stall_cnt", stall_cnt, 32'(stall_cycles));
`endif

        // abort after pixel 13
        begin_frame(1'b1);
        send_pixels(0, 14, -1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_out_valid", 32'(u_if.out_valid), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        begin_frame(1'b1);
        send_pixels(0, NPIX, -1);
        finish_frame();

        // start pulsed while busy
        begin_frame(1'b1);
        send_pixels(0, NPIX, 5);
        finish_frame();

        // start together with abort while idle
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_ready", 32'(u_if.pix_ready), 32'd0);
        check("start_abort_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (LAT + 2) @(posedge clk);
        #1;

        // asynchronous reset in the middle of RUN
        begin_frame(1'b1);
        send_pixels(0, 10, -1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs_word(), 32'd0);
        check("async_reset_state", 32'(dbg_state), 32'(ST_IDLE));
        u_if.pix_valid = 1'b0;
        exp_q.delete();
        frames_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        begin_frame(1'b1);
        send_pixels(0, NPIX, -1);
        finish_frame();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
